// File: rtl/fb_port_arbiter.sv
// Frame buffer port arbiter: scanout reads have fixed priority over pixel writes, with a
// starvation guard that forces one write slot after STARVE_LIMIT consecutive denials.
module fb_port_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned RAM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              starved
);
    localparam int unsigned      CNT_W  = 8;
    localparam int unsigned      PIPE_D = RAM_LATENCY + 1;
    localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARB      = 2'd1,
        FORCE_WR = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  starve_cnt_next;
    logic [PIPE_D-1:0] rd_pipe;
    logic              grant_rd;
    logic              grant_wr;

    // Per-cycle grant; nothing is granted while reset is held
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (reset) begin
            if (state == FORCE_WR && wr_req) begin
                grant_wr = 1'b1;
            end else if (rd_req) begin
                grant_rd = 1'b1;
            end else if (wr_req) begin
                grant_wr = 1'b1;
            end
        end
    end

    // Consecutive denied-writer cycles, saturating at the limit
    always_comb begin
        starve_cnt_next = '0;
        if (wr_req && !grant_wr) begin
            starve_cnt_next = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + CNT_W'(1);
        end
    end

    assign rd_ack   = grant_rd;
    assign wr_ack   = grant_wr;
    assign rd_valid = rd_pipe[PIPE_D-1];
    assign rd_data  = ram_rdata;
    assign starved  = (state == FORCE_WR);

    // FSM, starvation counter, RAM command stage and read-return pipe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_we     <= 1'b0;
            rd_pipe    <= '0;
        end else begin
            starve_cnt <= starve_cnt_next;
            rd_pipe    <= {rd_pipe[PIPE_D-2:0], grant_rd};

            if (grant_wr) begin
                ram_addr  <= wr_addr;
                ram_wdata <= wr_data;
                ram_we    <= 1'b1;
            end else if (grant_rd) begin
                ram_addr  <= rd_addr;
                ram_we    <= 1'b0;
            end else begin
                ram_we    <= 1'b0;
            end

            // The forced slot is entered on the edge where the count reaches the limit
            case (state)
                IDLE: begin
                    if (starve_cnt_next == LIMIT) begin
                        state <= FORCE_WR;
                    end else if (rd_req || wr_req) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    if (starve_cnt_next == LIMIT) begin
                        state <= FORCE_WR;
                    end else if (!rd_req && !wr_req) begin
                        state <= IDLE;
                    end
                end
                FORCE_WR: begin
                    state <= ARB;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model with its own shadow memory.
module tb_fb_port_arbiter;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned RAM_LAT = 1;
    localparam int unsigned LIMIT   = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_ack;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_ack;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic              starved;

    int checks = 0;
    int failures = 0;

    fb_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LATENCY(RAM_LAT), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .starved(starved)
    );

    always #5 clk = ~clk;

    // Write-first single-port RAM with RAM_LAT cycles of read latency
    bit [DATA_W-1:0] mem [65536];
    bit [DATA_W-1:0] rd_stage [RAM_LAT];
    logic              pre_en = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [DATA_W-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        rd_stage[0] <= ram_we ? ram_wdata : mem[ram_addr];
        for (int i = 1; i < int'(RAM_LAT); i++) rd_stage[i] <= rd_stage[i-1];
    end
    assign ram_rdata = rd_stage[RAM_LAT-1];

    typedef struct {
        int              due;
        logic [DATA_W-1:0] data;
    } exp_rd_t;

    bit [DATA_W-1:0] shadow [65536];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rd_req = 1'b0;
        wr_req = 1'b0;
        repeat (n) tick();
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; rd_req = 1'b1; wr_req = 1'b1;
        rd_addr = 16'h0003; wr_addr = 16'h0004; wr_data = 16'h9999;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (rd_ack !== 1'b0) begin failures++; $display("FAIL reset_rd_ack: got %b want 0", rd_ack); end
        checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL reset_wr_ack: got %b want 0", wr_ack); end
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        checks++; if (ram_addr !== 16'h0000) begin failures++; $display("FAIL reset_ram_addr: got %h want 0000", ram_addr); end
        checks++; if (starved !== 1'b0) begin failures++; $display("FAIL reset_starved: got %b want 0", starved); end
        tick();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (rd_ack !== 1'b1) begin failures++; $display("FAIL release_rd_ack: got %b want 1", rd_ack); end
        checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL release_wr_ack: got %b want 0", wr_ack); end
        tick();
        idle(6);
    endtask

    task automatic test_read_only();
        logic [DATA_W-1:0] exp_w [4];
        exp_w = '{16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000};
        for (int i = 0; i < 4; i++) preload(16'(i), exp_w[i]);
        idle(2);
        for (int c = 0; c < 8; c++) begin
            rd_req  = (c < 4);
            rd_addr = 16'(c);
            @(negedge clk);
            checks++;
            if (rd_ack !== 1'((c < 4))) begin failures++; $display("FAIL rdonly_ack c=%0d: got %b want %b", c, rd_ack, (c < 4)); end
            checks++;
            if (rd_valid !== 1'((c >= 2 && c <= 5))) begin failures++; $display("FAIL rdonly_valid c=%0d: got %b want %b", c, rd_valid, (c >= 2 && c <= 5)); end
            if (c >= 2 && c <= 5) begin
                checks++;
                if (rd_data !== exp_w[c-2]) begin failures++; $display("FAIL rdonly_data c=%0d: got %h want %h", c, rd_data, exp_w[c-2]); end
            end
            tick();
        end
        idle(2);
    endtask

    task automatic test_write_only();
        wr_req = 1'b1; wr_addr = 16'h5DBF; wr_data = 16'h1234;
        @(negedge clk);
        checks++; if (wr_ack !== 1'b1) begin failures++; $display("FAIL wronly_ack: got %b want 1", wr_ack); end
        checks++; if (rd_ack !== 1'b0) begin failures++; $display("FAIL wronly_rd_ack: got %b want 0", rd_ack); end
        tick();
        wr_req = 1'b0;
        checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL wronly_we: got %b want 1", ram_we); end
        checks++; if (ram_addr !== 16'h5DBF) begin failures++; $display("FAIL wronly_addr: got %h want 5dbf", ram_addr); end
        checks++; if (ram_wdata !== 16'h1234) begin failures++; $display("FAIL wronly_wdata: got %h want 1234", ram_wdata); end
        tick();
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL wronly_we_drop: got %b want 0", ram_we); end
        checks++; if (ram_addr !== 16'h5DBF) begin failures++; $display("FAIL wronly_addr_hold: got %h want 5dbf", ram_addr); end
        idle(2);
    endtask

    task automatic test_contention();
        bit fw;
        rd_req = 1'b1; rd_addr = 16'h0001;
        wr_req = 1'b1; wr_addr = 16'h0020; wr_data = 16'hC0DE;
        for (int c = 0; c < 27; c++) begin
            fw = ((c % 9) == 8);
            @(negedge clk);
            checks++;
            if (rd_ack !== !fw) begin failures++; $display("FAIL contend_rd_ack c=%0d: got %b want %b", c, rd_ack, !fw); end
            checks++;
            if (wr_ack !== fw) begin failures++; $display("FAIL contend_wr_ack c=%0d: got %b want %b", c, wr_ack, fw); end
            checks++;
            if (starved !== fw) begin failures++; $display("FAIL contend_starved c=%0d: got %b want %b", c, starved, fw); end
            tick();
        end
        idle(6);
    endtask

    task automatic test_write_then_read();
        wr_req = 1'b1; wr_addr = 16'h0010; wr_data = 16'hBEEF;
        @(negedge clk);
        checks++; if (wr_ack !== 1'b1) begin failures++; $display("FAIL wtr_wr_ack: got %b want 1", wr_ack); end
        tick();
        wr_req = 1'b0;
        for (int c = 1; c < 6; c++) begin
            rd_req = (c == 1); rd_addr = 16'h0010;
            @(negedge clk);
            checks++;
            if (rd_valid !== 1'((c == 3))) begin failures++; $display("FAIL wtr_valid c=%0d: got %b want %b", c, rd_valid, (c == 3)); end
            if (c == 3) begin
                checks++;
                if (rd_data !== 16'hBEEF) begin failures++; $display("FAIL wtr_data: got %h want beef", rd_data); end
            end
            tick();
        end
        idle(2);
    endtask

    task automatic test_reset_inflight();
        rd_req = 1'b1;
        for (int c = 0; c < 2; c++) begin
            rd_addr = 16'(c);
            tick();
        end
        rd_req = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL inflight_during_reset: got %b want 0", rd_valid); end
        repeat (2) tick();
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (rd_valid !== 1'b0) begin failures++; $display("FAIL inflight_after_release c=%0d: got %b want 0", c, rd_valid); end
            tick();
        end
        rd_req = 1'b1; rd_addr = 16'h0001;
        tick();
        rd_req = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL inflight_new_valid: got %b want 1", rd_valid); end
        checks++; if (rd_data !== 16'h5555) begin failures++; $display("FAIL inflight_new_data: got %h want 5555", rd_data); end
        tick();
        idle(3);
    endtask

    // Randomized traffic against a request-level model of priority and the write guarantee
    task automatic test_random(input int n, input int rd_pct, input int wr_pct);
        exp_rd_t           q[$];
        bit                m_force, rp, wp, g_rd, g_wr, e_valid, e_we, prev_grant, wreq;
        int                m_cnt;
        logic [ADDR_W-1:0] ra, wa, e_addr;
        logic [DATA_W-1:0] wd, e_wdata, e_data;
        m_force = 0; m_cnt = 0; rp = 0; wp = 0; e_we = 0; prev_grant = 0;
        ra = '0; wa = '0; wd = '0; e_addr = '0; e_wdata = '0;
        for (int c = 0; c < n; c++) begin
            if (c > 0) begin
                checks++;
                if (ram_we !== e_we) begin failures++; $display("FAIL rand_ram_we c=%0d: got %b want %b", c, ram_we, e_we); end
                if (prev_grant) begin
                    checks++;
                    if (ram_addr !== e_addr) begin failures++; $display("FAIL rand_ram_addr c=%0d: got %h want %h", c, ram_addr, e_addr); end
                end
                if (e_we) begin
                    checks++;
                    if (ram_wdata !== e_wdata) begin failures++; $display("FAIL rand_ram_wdata c=%0d: got %h want %h", c, ram_wdata, e_wdata); end
                end
            end
            if (c < n - 20) begin
                if (!rp && $urandom_range(99) < rd_pct) begin
                    rp = 1; ra = 16'h0100 + 16'($urandom_range(15));
                end
                if (!wp && $urandom_range(99) < wr_pct) begin
                    wp = 1; wa = 16'h0100 + 16'($urandom_range(15)); wd = 16'($urandom);
                end
            end
            rd_req = rp; rd_addr = ra; wr_req = wp; wr_addr = wa; wr_data = wd;
            g_wr = (m_force && wp) || (!rp && wp);
            g_rd = rp && !g_wr;
            e_valid = (q.size() > 0) && (q[0].due == c);
            e_data = e_valid ? q[0].data : '0;
            @(negedge clk);
            checks++; if (rd_ack !== g_rd) begin failures++; $display("FAIL rand_rd_ack c=%0d: got %b want %b", c, rd_ack, g_rd); end
            checks++; if (wr_ack !== g_wr) begin failures++; $display("FAIL rand_wr_ack c=%0d: got %b want %b", c, wr_ack, g_wr); end
            checks++; if (starved !== m_force) begin failures++; $display("FAIL rand_starved c=%0d: got %b want %b", c, starved, m_force); end
            checks++; if (rd_valid !== e_valid) begin failures++; $display("FAIL rand_rd_valid c=%0d: got %b want %b", c, rd_valid, e_valid); end
            if (e_valid) begin
                checks++;
                if (rd_data !== e_data) begin failures++; $display("FAIL rand_rd_data c=%0d: got %h want %h", c, rd_data, e_data); end
                void'(q.pop_front());
            end
            wreq = wp;
            if (g_rd) begin
                q.push_back('{c + 1 + int'(RAM_LAT), shadow[ra]});
                rp = 0; e_addr = ra; e_we = 0;
            end else if (g_wr) begin
                shadow[wa] = wd;
                wp = 0; e_addr = wa; e_wdata = wd; e_we = 1;
            end else begin
                e_we = 0;
            end
            prev_grant = g_rd || g_wr;
            if (wreq && !g_wr) m_cnt = (m_cnt + 1 > int'(LIMIT)) ? int'(LIMIT) : m_cnt + 1;
            else m_cnt = 0;
            m_force = m_force ? 1'b0 : (m_cnt == int'(LIMIT));
            tick();
        end
        checks++;
        if (q.size() != 0) begin failures++; $display("FAIL rand_drain: got %0d outstanding want 0", q.size()); end
        idle(4);
    endtask

    initial begin
        test_reset();
        test_read_only();
        test_write_only();
        test_contention();
        test_write_then_read();
        test_reset_inflight();
        test_random(300, 30, 30);
        test_random(300, 90, 60);
        test_random(200, 100, 100);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
